alien_hit_detector: RTL and testbench

- Produces the `kill_matrix` consumed by `alien_formation`: the other end of the alive/kill interface.
- Watches the VGA scan for overlap between the player-bullet pixel and any live alien's graphics bit, and latches at most one hit per frame.
- Reports the hit at the start of vertical blank: one-cycle kill pulse, bullet-consumed pulse and score update. Kills never land mid-frame.
- Also flags wave completion.

---
 rtl/alien_hit_detector.sv | 184 ++++++++++++++++++
 tb/tb_alien_hit_detector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alien_hit_detector.sv
// -----------------------------------------------------------------------------
// alien_hit_detector
//
// Watches the VGA scan for the player-bullet pixel landing on a live alien's
// graphics pixel. At most one hit is latched per frame; it is reported at the
// start of vertical blank with a one-cycle kill pulse, a bullet-consumed pulse
// and a score update, so kills never land mid-frame. Also pulses wave_clear
// when the formation becomes empty.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   scan_x, scan_y   current VGA column / row
//   graphics_matrix  per-alien "pixel is active" bits for the current pixel
//   alive_matrix     per-alien alive bits from alien_formation
//   bullet_pixel     player bullet covers the current scan pixel
//   enable           game active; gates new captures only
//   score_clear      synchronous score clear (wins over a coincident add)
//   kill_matrix      one-hot, one-cycle kill pulse back to alien_formation
//   bullet_hit       one-cycle pulse coincident with kill_matrix
//   hit_row, hit_col indices of the last reported hit, held until next report
//   score            saturating 16-bit accumulated score
//   wave_clear       one-cycle pulse on each transition to all-dead
// -----------------------------------------------------------------------------
module alien_hit_detector #(
  parameter int NUM_ROWS      = 2,
  parameter int NUM_COLUMNS   = 4,
  parameter int V_VISIBLE     = 480,
  parameter int H_VISIBLE     = 640,
  parameter int POINTS_TOP    = 30,
  parameter int POINTS_MID    = 20,
  parameter int POINTS_BOTTOM = 10
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [15:0]                           scan_x,
  input  logic [15:0]                           scan_y,
  input  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  graphics_matrix,
  input  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  alive_matrix,
  input  logic                                  bullet_pixel,
  input  logic                                  enable,
  input  logic                                  score_clear,
  output logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  kill_matrix,
  output logic                                  bullet_hit,
  output logic [7:0]                            hit_row,
  output logic [7:0]                            hit_col,
  output logic [15:0]                           score,
  output logic                                  wave_clear
);

  localparam int ROW_W = (NUM_ROWS    > 1) ? $clog2(NUM_ROWS)    : 1;
  localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int CELLS = NUM_ROWS * NUM_COLUMNS;

  typedef enum logic [1:0] {
    ARMED,
    CAPTURED,
    REPORT
  } state_t;

  state_t                               state;
  logic [ROW_W-1:0]                     cap_row;
  logic [COL_W-1:0]                     cap_col;
  logic                                 fe_cond_q;
  logic                                 all_dead_q;

  logic                                 visible;
  logic                                 fe_cond;
  logic                                 frame_end;
  logic                                 all_dead;
  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] overlap;
  logic                                 any_overlap;
  logic [ROW_W-1:0]                     sel_row;
  logic [COL_W-1:0]                     sel_col;
  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] kill_onehot;
  logic                                 cap_alive;
  logic [15:0]                          points;
  logic [16:0]                          score_sum;
  logic [15:0]                          score_sat;

  assign visible  = (scan_x < 16'(H_VISIBLE)) && (scan_y < 16'(V_VISIBLE));
  assign overlap  = {CELLS{bullet_pixel & visible}} & graphics_matrix & alive_matrix;
  assign any_overlap = |overlap;

  // The frame-end scan position can persist for many clocks when clk is
  // faster than the pixel clock; the edge detect gives one pulse per frame.
  assign fe_cond   = (scan_x == 16'd0) && (scan_y == 16'(V_VISIBLE));
  assign frame_end = fe_cond & ~fe_cond_q;

  assign all_dead  = (alive_matrix == '0);

  // Capture priority: the highest row index (closest to the player) wins,
  // then the lowest column. Later loop iterations override earlier ones, so
  // rows ascend and columns descend.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sel_row = '0;
    sel_col = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = NUM_COLUMNS - 1; c >= 0; c--) begin
        if (overlap[r][c]) begin
          sel_row = ROW_W'(r);
          sel_col = COL_W'(c);
        end
      end
    end
  end

  always_comb begin
    kill_onehot                   = '0;
    kill_onehot[cap_row][cap_col] = 1'b1;
  end

  // The alien may have died by other means between capture and report; it
  // still gets the kill pulse but earns no points.
  assign cap_alive = alive_matrix[cap_row][cap_col];

  always_comb begin
    if (cap_row == '0)
      points = 16'(POINTS_TOP);
    else if (cap_row == ROW_W'(NUM_ROWS - 1))
      points = 16'(POINTS_BOTTOM);
    else
      points = 16'(POINTS_MID);
  end

  assign score_sum = {1'b0, score} + {1'b0, points};
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARMED;
      cap_row     <= '0;
      cap_col     <= '0;
      fe_cond_q   <= 1'b0;
      all_dead_q  <= 1'b1;
      kill_matrix <= '0;
      bullet_hit  <= 1'b0;
      hit_row     <= '0;
      hit_col     <= '0;
      score       <= '0;
      wave_clear  <= 1'b0;
    end else begin
      fe_cond_q   <= fe_cond;
      all_dead_q  <= all_dead;
      wave_clear  <= all_dead & ~all_dead_q;
      kill_matrix <= '0;
      bullet_hit  <= 1'b0;

      case (state)
        ARMED: begin
          if (enable && any_overlap) begin
            cap_row <= sel_row;
            cap_col <= sel_col;
            state   <= CAPTURED;
          end
        end
        CAPTURED: begin
          // enable is deliberately ignored: a captured hit is always reported.
          if (frame_end) begin
            kill_matrix <= kill_onehot;
            bullet_hit  <= 1'b1;
            hit_row     <= 8'(cap_row);
            hit_col     <= 8'(cap_col);
            state       <= REPORT;
          end
        end
        REPORT: begin
          if (cap_alive)
            score <= score_sat;
          state <= ARMED;
        end
        default: state <= ARMED;
      endcase

      // Placed last so a clear coincident with REPORT discards the points.
      if (score_clear)
        score <= '0;
    end
  end

endmodule

// File: tb/tb_alien_hit_detector.sv
// -----------------------------------------------------------------------------
// tb_alien_hit_detector
//
// Directed self-checking bench for alien_hit_detector (NUM_ROWS=2,
// NUM_COLUMNS=4). Scan positions are driven directly rather than sweeping a
// whole frame, so each hit is: one overlap pixel, then the frame-end position
// (0,480), then a nearby blanking position to finish the REPORT cycle.
// Packed matrix bit index is row*4 + col.
// -----------------------------------------------------------------------------
module tb_alien_hit_detector;

  logic             clk;
  logic             rst_n;
  logic [15:0]      scan_x;
  logic [15:0]      scan_y;
  logic [1:0][3:0]  graphics_matrix;
  logic [1:0][3:0]  alive_matrix;
  logic             bullet_pixel;
  logic             enable;
  logic             score_clear;
  logic [1:0][3:0]  kill_matrix;
  logic             bullet_hit;
  logic [7:0]       hit_row;
  logic [7:0]       hit_col;
  logic [15:0]      score;
  logic             wave_clear;

  int tests_run    = 0;
  int tests_failed = 0;

  alien_hit_detector dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .scan_x          (scan_x),
    .scan_y          (scan_y),
    .graphics_matrix (graphics_matrix),
    .alive_matrix    (alive_matrix),
    .bullet_pixel    (bullet_pixel),
    .enable          (enable),
    .score_clear     (score_clear),
    .kill_matrix     (kill_matrix),
    .bullet_hit      (bullet_hit),
    .hit_row         (hit_row),
    .hit_col         (hit_col),
    .score           (score),
    .wave_clear      (wave_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One visible pixel with the bullet on it and the given graphics bits.
  task automatic hit_pixel(input logic [15:0] x, input logic [15:0] y,
                           input logic [7:0] gfx);
    scan_x          = x;
    scan_y          = y;
    graphics_matrix = gfx;
    bullet_pixel    = 1'b1;
    step();
    bullet_pixel    = 1'b0;
    graphics_matrix = '0;
  endtask

  // Move to the frame-end position; afterwards the DUT is in REPORT.
  task automatic to_frame_end();
    scan_x = 16'd0;
    scan_y = 16'd480;
    step();
  endtask

  // Leave the frame-end position; afterwards REPORT has completed.
  task automatic leave_frame_end();
    scan_x = 16'd1;
    scan_y = 16'd480;
    step();
    scan_x = 16'd0;
    scan_y = 16'd0;
  endtask

  initial begin
    rst_n           = 1'b0;
    scan_x          = 16'd0;
    scan_y          = 16'd0;
    graphics_matrix = '0;
    alive_matrix    = 8'hFF;
    bullet_pixel    = 1'b0;
    enable          = 1'b1;
    score_clear     = 1'b0;

    // Reset state
    #12;
    check("rst_kill",  32'(kill_matrix), 32'h00);
    check("rst_bhit",  32'(bullet_hit),  32'h0);
    check("rst_score", 32'(score),       32'h0);
    check("rst_row",   32'(hit_row),     32'h0);
    check("rst_wave",  32'(wave_clear),  32'h0);
    rst_n = 1'b1;
    step();
    check("no_wave_after_rst", 32'(wave_clear), 32'h0);

    // Basic hit at (1,2): reported one cycle after frame_end, row 1 = 10 pts
    hit_pixel(16'd10, 16'd100, 8'h40);
    check("t1_no_midframe_kill", 32'(kill_matrix), 32'h00);
    to_frame_end();
    check("t1_kill", 32'(kill_matrix), 32'h40);
    check("t1_bhit", 32'(bullet_hit),  32'h1);
    check("t1_row",  32'(hit_row),     32'h1);
    check("t1_col",  32'(hit_col),     32'h2);
    leave_frame_end();
    check("t1_kill_off", 32'(kill_matrix), 32'h00);
    check("t1_bhit_off", 32'(bullet_hit),  32'h0);
    check("t1_score",    32'(score),       32'd10);
    check("t1_row_held", 32'(hit_row),     32'h1);

    // One kill per frame: (0,3) first, later (1,0) ignored; +30
    hit_pixel(16'd20, 16'd60, 8'h08);
    hit_pixel(16'd30, 16'd90, 8'h10);
    to_frame_end();
    check("t2_kill", 32'(kill_matrix), 32'h08);
    check("t2_row",  32'(hit_row),     32'h0);
    check("t2_col",  32'(hit_col),     32'h3);
    leave_frame_end();
    check("t2_score", 32'(score), 32'd40);
    to_frame_end();
    check("t2_no_second_kill", 32'(kill_matrix), 32'h00);
    check("t2_no_second_bhit", 32'(bullet_hit),  32'h0);
    leave_frame_end();

    // Simultaneous (0,1) and (1,1): bottom row wins; +10
    hit_pixel(16'd40, 16'd200, 8'h22);
    to_frame_end();
    check("t3_kill", 32'(kill_matrix), 32'h20);
    check("t3_col",  32'(hit_col),     32'h1);
    leave_frame_end();
    check("t3_score", 32'(score), 32'd50);

    // Captured (0,0) dies before frame_end: pulse but no points
    hit_pixel(16'd50, 16'd10, 8'h01);
    alive_matrix = 8'hFE;
    to_frame_end();
    check("t4_kill", 32'(kill_matrix), 32'h01);
    check("t4_bhit", 32'(bullet_hit),  32'h1);
    leave_frame_end();
    check("t4_score", 32'(score), 32'd50);
    alive_matrix = 8'hFF;

    // enable low: no capture
    enable = 1'b0;
    hit_pixel(16'd60, 16'd10, 8'h01);
    enable = 1'b1;
    to_frame_end();
    check("t5_enable_low_kill", 32'(kill_matrix), 32'h00);
    leave_frame_end();

    // Overlap outside the visible area: ignored
    hit_pixel(16'd640, 16'd100, 8'h01);
    to_frame_end();
    check("t6_offscreen_kill", 32'(kill_matrix), 32'h00);
    leave_frame_end();
    check("t6_score", 32'(score), 32'd50);

    // Saturation: clear, then 2184 row-0 kills = 0xFFF0, one more -> 0xFFFF
    score_clear = 1'b1;
    step();
    score_clear = 1'b0;
    check("t7_cleared", 32'(score), 32'd0);
    for (int i = 0; i < 2184; i++) begin
      hit_pixel(16'd5, 16'd5, 8'h01);
      to_frame_end();
      leave_frame_end();
    end
    check("t7_near_limit", 32'(score), 32'hFFF0);
    hit_pixel(16'd5, 16'd5, 8'h01);
    to_frame_end();
    leave_frame_end();
    check("t7_saturated", 32'(score), 32'hFFFF);

    // Reset mid-frame with a captured hit discards it
    hit_pixel(16'd70, 16'd100, 8'h10);
    rst_n = 1'b0;
    #2;
    check("t8_rst_score", 32'(score), 32'h0);
    rst_n = 1'b1;
    to_frame_end();
    check("t8_kill", 32'(kill_matrix), 32'h00);
    check("t8_bhit", 32'(bullet_hit),  32'h0);
    check("t8_col",  32'(hit_col),     32'h0);
    leave_frame_end();

    // score_clear coincident with REPORT wins
    hit_pixel(16'd80, 16'd100, 8'h10);
    to_frame_end();
    leave_frame_end();
    check("t9_score_pre", 32'(score), 32'd10);
    hit_pixel(16'd80, 16'd100, 8'h02);
    to_frame_end();
    check("t9_kill", 32'(kill_matrix), 32'h02);
    score_clear = 1'b1;
    leave_frame_end();
    score_clear = 1'b0;
    check("t9_clear_wins", 32'(score), 32'd0);

    // wave_clear: one pulse per transition to all-dead
    alive_matrix = 8'h00;
    step();
    check("t10_wave_pulse", 32'(wave_clear), 32'h1);
    step();
    check("t10_wave_once", 32'(wave_clear), 32'h0);
    step();
    step();
    check("t10_wave_held", 32'(wave_clear), 32'h0);
    alive_matrix = 8'h01;
    step();
    check("t10_wave_alive", 32'(wave_clear), 32'h0);
    alive_matrix = 8'h00;
    step();
    check("t10_wave_rearm", 32'(wave_clear), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
